alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DataWidth, 16, operand/result width
- FlagSize, 4, ALU flag width (bit0 Z, bit1 C, bit2 N, bit3 V)
- OpWidth, 4, ALU function-op width
- ExecCycles, 1, cycles to wait for ALU settle (legal 1..15)
REQ-002 Ports (name, direction, width, meaning), one per line; one clock, reset synchronous active-low:
- Clk, in, 1, sole clock, all state updates on rising edge
- Reset, in, 1, synchronous active-low reset
- Valid, in, 1, DIn (and OpIn in IDLE) carries a word
- Ready, out, 1, word on DIn accepted this cycle when Valid=1
- DIn, in, DataWidth, operand word (A first, then B)
- OpIn, in, OpWidth, function op, sampled with operand A
- Abort, in, 1, cancel current operation
- A, out, DataWidth, registered operand A to ALU
- B, out, DataWidth, registered operand B to ALU
- FuncOp, out, OpWidth, registered op to ALU
- Y, in, DataWidth, ALU result
- IFlags, in, FlagSize, ALU output flags
- LD, out, 1, one-cycle load strobe to downstream result/flag registers
- Result, out, DataWidth, captured Y
- Flags, out, FlagSize, captured IFlags
- Done, out, 1, one-cycle completion pulse
- Busy, out, 1, state is not IDLE
- OpCount, out, 8, completed-operation count

Function
REQ-003 States: IDLE, GET_B, EXEC, CAPTURE; state encoding in registered flops.
REQ-004 Ready = 1 in IDLE and GET_B, 0 in EXEC and CAPTURE, 0 while Reset=0.
REQ-005 IDLE: Valid&Ready -> A<=DIn, FuncOp<=OpIn, go GET_B; else stay.
REQ-006 GET_B: Valid&Ready -> B<=DIn, load exec counter with ExecCycles-1, go EXEC; else stay indefinitely.
REQ-007 EXEC: counter decrements per cycle; at 0 go CAPTURE; EXEC lasts exactly ExecCycles cycles.
REQ-008 CAPTURE: LD=1 this cycle only; Result<=Y, Flags<=IFlags at end of cycle; OpCount+1; go IDLE.
REQ-009 Done = 1 exactly in the cycle after CAPTURE (first IDLE cycle); a new A may be accepted that same cycle.
REQ-010 Latency: A accepted cycle t, B at t+1 -> LD at t+2+ExecCycles, Done at t+3+ExecCycles.
REQ-011 A, B, FuncOp hold stable from acceptance until the next A/B acceptance; never change during EXEC/CAPTURE.
REQ-012 Valid in EXEC/CAPTURE ignored; upstream holds word until Ready.
REQ-013 Abort=1 in any state: next state IDLE, no LD, no Done, OpCount/Result/Flags unchanged; Abort overrides Valid (word discarded, Ready still reads 1 but no capture).
REQ-014 Abort in CAPTURE: capture suppressed (LD=0 that cycle).
REQ-015 OpCount wraps 255 -> 0.
REQ-016 Busy = 1 in GET_B, EXEC, CAPTURE.

Reset
REQ-017 Reset=0 at rising Clk: state IDLE; A, B, Result = 0; FuncOp = 0; Flags = 0; OpCount = 0; LD, Done = 0; Busy = 0.
REQ-018 Reset mid-operation aborts with no LD/Done; Reset has priority over Abort and Valid.

Structure
REQ-019 Shared package holds state encoding constants and flag bit indices (Z, C, N, V); DataWidth/FlagSize/OpWidth defaults match the CPU-wide constants.
REQ-020 One sub-module natural: exec_timer (loadable 4-bit down-counter with zero flag); all else in alu_sequencer.

Verification (bench models ALU combinationally: Y/IFlags from A, B, FuncOp)
REQ-021 ExecCycles=1; A=0x0012 op=4'h1, B=0x0015 next cycle -> LD at t+3, Done at t+4, Result=0x0027 for add model, Flags captured.
REQ-022 Valid dropped after A for 5 cycles -> stays GET_B, Busy=1, Ready=1, no LD until B arrives.
REQ-023 Abort asserted in EXEC (ExecCycles=4) -> IDLE next cycle, no LD/Done, Result and OpCount unchanged.
REQ-024 Back-to-back ops: new A driven in Done cycle -> accepted, second result correct, OpCount=2.
REQ-025 256 completed ops -> OpCount returns to 0x00.
REQ-026 Reset=0 during GET_B -> all outputs at reset values next cycle, Ready=0 while asserted.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: CPU-wide widths,
// sequencer state encoding and ALU flag bit positions.
package alu_sequencer_pkg;

   // CPU-wide datapath constants
   localparam int CPU_DATA_WIDTH = 16;
   localparam int CPU_FLAG_SIZE  = 4;
   localparam int CPU_OP_WIDTH   = 4;

   // Bit positions inside the ALU flag vector
   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   // Width of the execute-wait down-counter
   localparam int TIMER_WIDTH = 4;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GET_B   = 2'd1,
      ST_EXEC    = 2'd2,
      ST_CAPTURE = 2'd3
   } seq_state_t;

   // The timer reaches zero in the last execute cycle, so it is preloaded
   // with one less than the number of settle cycles.
   function automatic logic [TIMER_WIDTH-1:0] exec_load_value(input int cycles);
      return TIMER_WIDTH'(cycles - 1);
   endfunction

endpackage

// File: rtl/alu_sequencer_timer.sv
// Loadable 4-bit down-counter; counts toward zero and holds there.
module exec_timer
   import alu_sequencer_pkg::*;
(
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   load,
   input  logic [TIMER_WIDTH-1:0] load_value,
   output logic                   zero
);

   logic [TIMER_WIDTH-1:0] count;

   // Load takes priority; otherwise decrement until zero is reached
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Feeds operands A/B and an op to an external combinational ALU, waits for
// it to settle, then strobes the result and flags into output registers.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int DataWidth  = CPU_DATA_WIDTH,
   parameter int FlagSize   = CPU_FLAG_SIZE,
   parameter int OpWidth    = CPU_OP_WIDTH,
   parameter int ExecCycles = 1              // settle cycles, legal 1..15
)(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Valid,
   output logic                 Ready,
   input  logic [DataWidth-1:0] DIn,
   input  logic [OpWidth-1:0]   OpIn,
   input  logic                 Abort,
   output logic [DataWidth-1:0] A,
   output logic [DataWidth-1:0] B,
   output logic [OpWidth-1:0]   FuncOp,
   input  logic [DataWidth-1:0] Y,
   input  logic [FlagSize-1:0]  IFlags,
   output logic                 LD,
   output logic [DataWidth-1:0] Result,
   output logic [FlagSize-1:0]  Flags,
   output logic                 Done,
   output logic                 Busy,
   output logic [7:0]           OpCount
);

   localparam logic [TIMER_WIDTH-1:0] EXEC_LOAD = exec_load_value(ExecCycles);

   seq_state_t state;
   logic       ld_reg;
   logic       done_reg;
   logic       timer_load;
   logic       timer_zero;

   // Ready is a pure state decode, forced low while reset is held
   assign Ready = Reset && (state == ST_IDLE || state == ST_GET_B);
   assign Busy  = (state != ST_IDLE);
   // Abort arriving in the capture cycle must still kill the load strobe
   assign LD    = ld_reg && !Abort && Reset;
   assign Done  = done_reg;

   // Arm the settle timer as operand B is accepted
   assign timer_load = (state == ST_GET_B) && Valid && !Abort;

   exec_timer u_timer (
      .Clk        (Clk),
      .Reset      (Reset),
      .load       (timer_load),
      .load_value (EXEC_LOAD),
      .zero       (timer_zero)
   );

   // Sequencer FSM with registered operand, result and strobe outputs
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state    <= ST_IDLE;
         A        <= '0;
         B        <= '0;
         FuncOp   <= '0;
         Result   <= '0;
         Flags    <= '0;
         OpCount  <= '0;
         ld_reg   <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         ld_reg   <= 1'b0;
         done_reg <= 1'b0;
         if (Abort) begin
            // Abort discards any word on DIn and any pending capture
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (Valid) begin
                     A      <= DIn;
                     FuncOp <= OpIn;
                     state  <= ST_GET_B;
                  end
               end
               ST_GET_B: begin
                  if (Valid) begin
                     B     <= DIn;
                     state <= ST_EXEC;
                  end
               end
               ST_EXEC: begin
                  if (timer_zero) begin
                     ld_reg <= 1'b1;
                     state  <= ST_CAPTURE;
                  end
               end
               ST_CAPTURE: begin
                  Result   <= Y;
                  Flags    <= IFlags;
                  OpCount  <= OpCount + 8'd1;
                  done_reg <= 1'b1;
                  state    <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a combinational ALU model answers the
// DUT, stimulus pushes expected results, a monitor checks each Done pulse.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   localparam int DW   = 16;
   localparam int FW   = 4;
   localparam int OW   = 4;
   localparam int EXEC = 4;

   logic          Clk = 1'b0;
   logic          Reset, Valid, Ready, Abort, LD, Done, Busy;
   logic [DW-1:0] DIn, A, B, Y, Result;
   logic [OW-1:0] OpIn, FuncOp;
   logic [FW-1:0] IFlags, Flags;
   logic [7:0]    OpCount;
   logic [19:0]   alu_out;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  flg;
      logic [7:0]  cnt;
      int          done_cyc;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          issued = 0;
   int          cyc = 0;
   int          ld_cyc = -10;
   logic [15:0] last_res = '0;

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   alu_sequencer #(
      .DataWidth(DW), .FlagSize(FW), .OpWidth(OW), .ExecCycles(EXEC)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Valid(Valid), .Ready(Ready), .DIn(DIn),
      .OpIn(OpIn), .Abort(Abort), .A(A), .B(B), .FuncOp(FuncOp), .Y(Y),
      .IFlags(IFlags), .LD(LD), .Result(Result), .Flags(Flags), .Done(Done),
      .Busy(Busy), .OpCount(OpCount)
   );

   // ALU behaviour: 1 add, 2 sub, 3 and, 4 or, 5 xor, others pass A
   function automatic logic [19:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] op);
      logic [16:0] wide;
      logic [15:0] y;
      logic [3:0]  f;
      f    = '0;
      wide = '0;
      case (op)
         4'h1: begin
            wide      = {1'b0, a} + {1'b0, b};
            y         = wide[15:0];
            f[FLAG_C] = wide[16];
            f[FLAG_V] = (a[15] == b[15]) && (y[15] != a[15]);
         end
         4'h2: begin
            wide      = {1'b0, a} - {1'b0, b};
            y         = wide[15:0];
            f[FLAG_C] = (a < b);
            f[FLAG_V] = (a[15] != b[15]) && (y[15] != a[15]);
         end
         4'h3:    y = a & b;
         4'h4:    y = a | b;
         4'h5:    y = a ^ b;
         default: y = a;
      endcase
      f[FLAG_Z] = (y == 16'h0000);
      f[FLAG_N] = y[15];
      return {f, y};
   endfunction

   always_comb alu_out = alu_model(A, B, FuncOp);
   assign Y      = alu_out[15:0];
   assign IFlags = alu_out[19:16];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   // Monitor: every Done pops one expectation; LD/Done with nothing pending is an error
   always @(negedge Clk) begin : monitor
      exp_t e;
      if (Reset === 1'b1) begin
         if (LD === 1'b1) begin
            ld_cyc = cyc;
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_ld: LD=1 at cycle %0d, required 0", cyc);
            end
         end
         if (Done === 1'b1) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_done: Done=1 at cycle %0d, required 0", cyc);
            end else begin
               e = sb.pop_front();
               check("result", Result, e.res);
               check("flags", Flags, e.flg);
               check("opcount", OpCount, e.cnt);
               check("done_cycle", cyc, e.done_cyc);
               check("ld_cycle", ld_cyc, cyc - 1);
               $display("op done: cycle=%0d result=%h flags=%h opcount=%0d",
                        cyc, Result, Flags, OpCount);
            end
         end
      end
   end

   // Present one word and hold it until the DUT accepts it
   task automatic send(input logic [15:0] w, input logic [3:0] op, output int acc);
      int n;
      n     = 0;
      Valid = 1'b1;
      DIn   = w;
      OpIn  = op;
      while (Ready !== 1'b1 && n < 100) begin
         @(posedge Clk); #1;
         n++;
      end
      if (Ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL send_timeout: Ready=%b required=1", Ready);
         acc = -1;
      end else begin
         acc = cyc;
      end
      @(posedge Clk); #1;
      Valid = 1'b0;
      DIn   = 16'($urandom);
   endtask

   // Full operation: A, optional idle gap in GET_B, B, then queue the expectation
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input int gap, output int ta, output int dcyc);
      int          tb;
      logic [19:0] r;
      exp_t        e;
      send(a, op, ta);
      for (int i = 0; i < gap; i++) begin
         check("gap_busy", Busy, 1);
         check("gap_ready", Ready, 1);
         check("gap_ld", LD, 0);
         @(posedge Clk); #1;
      end
      send(b, 4'h0, tb);
      r          = alu_model(a, b, op);
      issued++;
      e.res      = r[15:0];
      e.flg      = r[19:16];
      e.cnt      = 8'(issued);
      e.done_cyc = tb + 2 + EXEC;
      dcyc       = e.done_cyc;
      last_res   = e.res;
      sb.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge Clk); #1;
         n++;
      end
      check("drain_empty", sb.size(), 0);
      @(posedge Clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ta, tb, d1, d2, a_abort;
      Reset = 1'b0; Valid = 1'b0; Abort = 1'b0; DIn = '0; OpIn = '0;
      repeat (3) begin @(posedge Clk); #1; end
      check("reset_ready", Ready, 0);
      check("reset_a", A, 0);
      check("reset_b", B, 0);
      check("reset_funcop", FuncOp, 0);
      check("reset_result", Result, 0);
      check("reset_flags", Flags, 0);
      check("reset_opcount", OpCount, 0);
      check("reset_ld", LD, 0);
      check("reset_done", Done, 0);
      check("reset_busy", Busy, 0);
      Reset = 1'b1;
      @(posedge Clk); #1;

      // Basic add with known numbers
      do_op(16'h0012, 16'h0015, 4'h1, 0, ta, d1);
      drain();
      check("add_result", Result, 16'h0027);
      check("add_flags", Flags, 4'h0);

      // Upstream stalls five cycles between A and B
      do_op(16'h8000, 16'h0001, 4'h2, 5, ta, d1);
      drain();

      // Abort in the second execute cycle
      send(16'h1111, 4'h1, ta);
      send(16'h2222, 4'h0, tb);
      @(posedge Clk); #1;
      Abort = 1'b1;
      @(posedge Clk); #1;
      Abort = 1'b0;
      check("abort_exec_busy", Busy, 0);
      check("abort_exec_ready", Ready, 1);
      repeat (EXEC + 4) begin @(posedge Clk); #1; end
      check("abort_exec_opcount", OpCount, 8'(issued));
      check("abort_exec_result", Result, last_res);

      // Abort in the capture cycle suppresses LD
      a_abort = 16'h3333;
      send(16'h3333, 4'h1, ta);
      send(16'h4444, 4'h0, tb);
      repeat (EXEC) begin @(posedge Clk); #1; end
      Abort = 1'b1;
      #1;
      check("abort_capture_ld", LD, 0);
      @(posedge Clk); #1;
      Abort = 1'b0;
      check("abort_capture_busy", Busy, 0);
      repeat (4) begin @(posedge Clk); #1; end
      check("abort_capture_opcount", OpCount, 8'(issued));
      check("abort_capture_result", Result, last_res);

      // Abort overrides Valid in IDLE
      Valid = 1'b1; Abort = 1'b1; DIn = 16'h5A5A;
      @(posedge Clk); #1;
      Valid = 1'b0; Abort = 1'b0;
      check("abort_idle_busy", Busy, 0);
      check("abort_idle_a", A, a_abort);

      // Back-to-back: second A must be accepted in the first op's Done cycle
      do_op(16'h7FFF, 16'h0001, 4'h1, 0, ta, d1);
      do_op(16'hF0F0, 16'h0FF0, 4'h5, 0, ta, d2);
      check("b2b_accept_cycle", ta, d1);
      drain();

      // Random traffic until 256 completed ops since reset
      while (issued < 256) begin
         do_op(16'($urandom), 16'($urandom), 4'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, ta, d1);
      end
      drain();
      check("opcount_wrap", OpCount, 8'h00);
      for (int i = 0; i < 8; i++) begin
         do_op(16'($urandom), 16'($urandom), 4'($urandom_range(1, 5)), 0, ta, d1);
      end
      drain();

      // Reset while waiting for operand B
      send(16'hABCD, 4'h3, ta);
      Reset = 1'b0;
      #1;
      check("rst_getb_ready_now", Ready, 0);
      @(posedge Clk); #1;
      check("rst_getb_ready", Ready, 0);
      check("rst_getb_a", A, 0);
      check("rst_getb_result", Result, 0);
      check("rst_getb_flags", Flags, 0);
      check("rst_getb_opcount", OpCount, 0);
      check("rst_getb_busy", Busy, 0);
      check("rst_getb_ld", LD, 0);
      check("rst_getb_done", Done, 0);
      Reset  = 1'b1;
      issued = 0;
      @(posedge Clk); #1;
      check("post_rst_ready", Ready, 1);
      do_op(16'h0100, 16'h0100, 4'h2, 0, ta, d1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
